pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute control FSM driving the program counter of the 16-bit CPU.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   run        level; starts execution from IDLE, ignored afterwards
//   instr      instruction word from ROM, [15:12] opcode, [11:0] operand
//   flag_z     ALU zero flag, sampled only in EXEC
//   flag_c     ALU carry flag, sampled only in EXEC
//   mem_ready  data memory access complete, looked at only in MEM
//   pc_load    PC load strobe (with pc_inc: clear PC to 0)
//   pc_inc     PC increment strobe
//   jump_addr  {4'b0, latched operand}, PC load value
//   ir_load    instruction register capture strobe
//   alu_op     ALU function: 0 pass, 1 add, 2 sub, 3 and, 4 or
//   reg_we     register file write strobe
//   mem_re     data memory read request, held until mem_ready
//   mem_we     data memory write request, held until mem_ready
//   halted     high while in HALT
//   illegal    sticky; set on an undefined opcode
//
// Every output is a register loaded from the next-state logic, so each
// strobe appears in the cycle after the state that decided it.
module pc_sequencer #(
    parameter int unsigned FETCH_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        mem_ready,
    output logic        pc_load,
    output logic        pc_inc,
    output logic [15:0] jump_addr,
    output logic        ir_load,
    output logic [2:0]  alu_op,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        halted,
    output logic        illegal
);
    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] RELOAD = 4'(FETCH_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [11:0] opr_q, opr_d;
    logic        pc_load_q, pc_load_d;
    logic        pc_inc_q, pc_inc_d;
    logic        ir_load_q, ir_load_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic        is_alu, take;

    assign is_alu = (op_q >= 4'h1) && (op_q <= 4'h4);
    // Branch taken: JMP always, JZ/JC on the flag seen during EXEC.
    assign take = (op_q == 4'h7) | ((op_q == 4'h8) & flag_z) | ((op_q == 4'h9) & flag_c);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opr_d     = opr_q;
        pc_load_d = 1'b0;
        pc_inc_d  = 1'b0;
        ir_load_d = 1'b0;
        alu_op_d  = 3'd0;
        reg_we_d  = 1'b0;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        halted_d  = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            S_CLEAR: begin
                pc_load_d = 1'b1;
                pc_inc_d  = 1'b1;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = RELOAD;
                end
            end
            S_FETCH: begin
                if (cnt_q == 4'd0) begin
                    ir_load_d = 1'b1;
                    op_d      = instr[15:12];
                    opr_d     = instr[11:0];
                    state_d   = S_DECODE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (op_q)
                    4'h1, 4'h2, 4'h3, 4'h4: alu_op_d = op_q[2:0];
                    4'h5: begin
                        mem_re_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    4'h6: begin
                        mem_we_d = 1'b1;
                        state_d  = S_MEM;
                    end
                    4'hA, 4'hB, 4'hC, 4'hD, 4'hE: illegal_d = 1'b1;
                    4'hF: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                // alu_op_q is nonzero only for ALU opcodes, so holding it is safe for all.
                alu_op_d  = alu_op_q;
                reg_we_d  = is_alu;
                pc_load_d = take;
                pc_inc_d  = !take;
                state_d   = S_FETCH;
                cnt_d     = RELOAD;
            end
            S_MEM: begin
                if (mem_ready) begin
                    reg_we_d = (op_q == 4'h5);
                    pc_inc_d = 1'b1;
                    state_d  = S_FETCH;
                    cnt_d    = RELOAD;
                end else begin
                    mem_re_d = mem_re_q;
                    mem_we_d = mem_we_q;
                end
            end
            S_HALT: halted_d = 1'b1;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            cnt_q     <= 4'd0;
            op_q      <= 4'd0;
            opr_q     <= 12'd0;
            pc_load_q <= 1'b0;
            pc_inc_q  <= 1'b0;
            ir_load_q <= 1'b0;
            alu_op_q  <= 3'd0;
            reg_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opr_q     <= opr_d;
            pc_load_q <= pc_load_d;
            pc_inc_q  <= pc_inc_d;
            ir_load_q <= ir_load_d;
            alu_op_q  <= alu_op_d;
            reg_we_q  <= reg_we_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc_load   = pc_load_q;
    assign pc_inc    = pc_inc_q;
    assign jump_addr = {4'b0, opr_q};
    assign ir_load   = ir_load_q;
    assign alu_op    = alu_op_q;
    assign reg_we    = reg_we_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with an instruction-level trace model.
module tb_pc_sequencer;
    localparam int FW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        flag_z = 1'b0;
    logic        flag_c = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_load, pc_inc, ir_load, reg_we, mem_re, mem_we, halted, illegal;
    logic [15:0] jump_addr;
    logic [2:0]  alu_op;

    typedef struct packed {
        logic        pl;
        logic        pi;
        logic [15:0] ja;
        logic        ir;
        logic [2:0]  alu;
        logic        we;
        logic        re;
        logic        wr;
        logic        h;
        logic        ill;
    } out_t;

    out_t        got;
    int          checks = 0;
    int          errors = 0;
    int          mre_cnt = 0;
    int          n0;
    logic [15:0] m_ja = 16'h0;
    logic        m_ill = 1'b0;

    pc_sequencer #(.FETCH_WAIT(FW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
        .flag_z(flag_z), .flag_c(flag_c), .mem_ready(mem_ready),
        .pc_load(pc_load), .pc_inc(pc_inc), .jump_addr(jump_addr),
        .ir_load(ir_load), .alu_op(alu_op), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign got = {pc_load, pc_inc, jump_addr, ir_load, alu_op, reg_we, mem_re, mem_we, halted, illegal};

    // Quiet output vector: no strobes, current operand and sticky illegal.
    function automatic out_t base();
        out_t o;
        o     = '0;
        o.ja  = m_ja;
        o.ill = m_ill;
        return o;
    endfunction

    task automatic lit(input string name, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, g, e);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, compare registered outputs at the next falling edge.
    task automatic step(input logic r, input logic [15:0] ins, input logic z, input logic c,
                        input logic rdy, input out_t e);
        run = r;
        instr = ins;
        flag_z = z;
        flag_c = c;
        mem_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        if (mem_re) mre_cnt++;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL trace t=%0t: got pl=%b pi=%b ja=%h ir=%b alu=%0d we=%b re=%b wr=%b h=%b ill=%b, expected pl=%b pi=%b ja=%h ir=%b alu=%0d we=%b re=%b wr=%b h=%b ill=%b",
                     $time, got.pl, got.pi, got.ja, got.ir, got.alu, got.we, got.re, got.wr, got.h, got.ill,
                     e.pl, e.pi, e.ja, e.ir, e.alu, e.we, e.re, e.wr, e.h, e.ill);
        end
    endtask

    // One instruction from the second FETCH cycle through its completion strobe.
    // Flags carry the inverse value except in EXEC; mem_ready is high except in MEM waits.
    task automatic do_instr(input logic [15:0] ins, input logic z, input logic c, input int d);
        logic [3:0] op;
        logic       take;
        out_t       e;
        op = ins[15:12];
        for (int i = 0; i < FW - 1; i++) step(1'b0, ins, !z, !c, 1'b1, base());
        m_ja = {4'h0, ins[11:0]};
        e = base();
        e.ir = 1'b1;
        step(1'b1, ins, !z, !c, 1'b1, e);
        if (op >= 4'hA && op <= 4'hE) m_ill = 1'b1;
        e = base();
        if (op == 4'h5 || op == 4'h6) begin
            e.re = (op == 4'h5);
            e.wr = (op == 4'h6);
            step(1'b0, ins, !z, !c, 1'b1, e);
            for (int i = 0; i < d; i++) step(1'b0, ins, !z, !c, 1'b0, e);
            e = base();
            e.we = (op == 4'h5);
            e.pi = 1'b1;
            step(1'b0, ins, !z, !c, 1'b1, e);
        end else if (op == 4'hF) begin
            e.h = 1'b1;
            step(1'b0, ins, !z, !c, 1'b1, e);
            for (int i = 0; i < 20; i++) step(i[0], ins, i[1], i[2], !i[0], e);
        end else begin
            if (op >= 4'h1 && op <= 4'h4) e.alu = op[2:0];
            step(1'b0, ins, !z, !c, 1'b1, e);
            take = (op == 4'h7) || (op == 4'h8 && z) || (op == 4'h9 && c);
            e.pl = take;
            e.pi = !take;
            e.we = (op >= 4'h1 && op <= 4'h4);
            step(1'b0, ins, z, c, 1'b1, e);
        end
    endtask

    initial begin
        out_t e;
        @(negedge clk);
        lit("reset_outputs", 32'(got), 32'd0);
        rst_n = 1'b1;
        e = base();
        e.pl = 1'b1;
        e.pi = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, e);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, base());
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, base());
        do_instr(16'h1000, 1'b0, 1'b0, 0);
        do_instr(16'h2345, 1'b1, 1'b0, 0);
        do_instr(16'h7ABC, 1'b0, 1'b0, 0);
        lit("jmp_addr", 32'(jump_addr), 32'h0ABC);
        do_instr(16'h8012, 1'b0, 1'b0, 0);
        do_instr(16'h8012, 1'b1, 1'b0, 0);
        lit("jz_addr", 32'(jump_addr), 32'h0012);
        do_instr(16'h9034, 1'b0, 1'b0, 0);
        do_instr(16'h9034, 1'b0, 1'b1, 0);
        n0 = mre_cnt;
        do_instr(16'h5004, 1'b0, 1'b0, 3);
        lit("load_mem_re_cycles", 32'(mre_cnt - n0), 32'd4);
        do_instr(16'h6007, 1'b0, 1'b0, 0);
        do_instr(16'h3000, 1'b0, 1'b0, 0);
        do_instr(16'h4000, 1'b0, 1'b0, 0);
        do_instr(16'h0000, 1'b0, 1'b0, 0);
        do_instr(16'hB000, 1'b0, 1'b0, 0);
        do_instr(16'h1111, 1'b0, 1'b0, 0);
        lit("illegal_sticky", 32'(illegal), 32'd1);
        do_instr(16'hF000, 1'b0, 1'b0, 0);
        lit("halted_level", 32'(halted), 32'd1);
        #2 rst_n = 1'b0;
        #1 lit("halt_async_reset", 32'({halted, illegal}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ja = 16'h0;
        m_ill = 1'b0;
        e = base();
        e.pl = 1'b1;
        e.pi = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, e);
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, base());
        for (int i = 0; i < FW - 1; i++) step(1'b0, 16'h6009, 1'b0, 1'b0, 1'b1, base());
        m_ja = 16'h0009;
        e = base();
        e.ir = 1'b1;
        step(1'b0, 16'h6009, 1'b0, 1'b0, 1'b1, e);
        e = base();
        e.wr = 1'b1;
        step(1'b0, 16'h6009, 1'b0, 1'b0, 1'b1, e);
        step(1'b0, 16'h6009, 1'b0, 1'b0, 1'b0, e);
        step(1'b0, 16'h6009, 1'b0, 1'b0, 1'b0, e);
        #2 rst_n = 1'b0;
        #1 lit("mem_we_async_clear", 32'(mem_we), 32'd0);
        lit("mid_reset_all_zero", 32'(got), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ja = 16'h0;
        e = base();
        e.pl = 1'b1;
        e.pi = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, e);
        step(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, base());
        do_instr(16'h2000, 1'b0, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
